// File: rtl/adder_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : adder_share_arbiter
//  Description : Round-robin arbiter that shares one WIDTH-bit adder
//                (sum = a + b + cin, with carry-out) between two requesters,
//                one operation in flight, optional one-stage datapath pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_share_arbiter #(
    parameter int WIDTH           = 4,
    parameter int PIPELINE_ENABLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    // requester 0
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic             i_req0_cin,
    output logic             o_req0_ready,
    // requester 1
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic             i_req1_cin,
    output logic             o_req1_ready,
    // response 0
    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [WIDTH-1:0] o_rsp0_sum,
    output logic             o_rsp0_cout,
    // response 1
    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [WIDTH-1:0] o_rsp1_sum,
    output logic             o_rsp1_cout,
    // status
    output logic             o_busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_prio;         // requester that wins a tie
    logic             r_id;           // requester owning the in-flight op
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp0_sum;
    logic [WIDTH-1:0] r_rsp1_sum;
    logic             r_rsp0_cout;
    logic             r_rsp1_cout;

    logic             w_idle;
    logic             w_grant1;
    logic             w_req_hs;
    logic             w_rsp_hs;
    logic [WIDTH-1:0] w_win_a;
    logic [WIDTH-1:0] w_win_b;
    logic             w_win_cin;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_op_cin;
    logic [WIDTH:0]   w_res;
    logic             w_load;         // write the adder result into the response regs
    logic             w_load_id;      // which response port gets that result

    // A lone requester always wins; a tie goes to the priority pointer.
    assign w_idle    = (r_state == S_IDLE);
    assign w_grant1  = i_req1_valid & (~i_req0_valid | r_prio);

    assign o_req0_ready = w_idle & ~rst & i_req0_valid & ~w_grant1;
    assign o_req1_ready = w_idle & ~rst & w_grant1;
    assign w_req_hs     = o_req0_ready | o_req1_ready;

    assign w_rsp_hs = (r_state == S_RESP) &
                      (r_id ? (r_rsp1_valid & i_rsp1_ready)
                            : (r_rsp0_valid & i_rsp0_ready));

    assign w_win_a   = w_grant1 ? i_req1_a   : i_req0_a;
    assign w_win_b   = w_grant1 ? i_req1_b   : i_req0_b;
    assign w_win_cin = w_grant1 ? i_req1_cin : i_req0_cin;

    generate
        if (PIPELINE_ENABLE != 0) begin : g_pipe
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic             r_cin;

            // Operand stage register: captured on accept, added during EXEC.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_cin <= 1'b0;
                end else if (w_req_hs) begin
                    r_a   <= w_win_a;
                    r_b   <= w_win_b;
                    r_cin <= w_win_cin;
                end
            end

            assign w_op_a    = r_a;
            assign w_op_b    = r_b;
            assign w_op_cin  = r_cin;
            assign w_load    = (r_state == S_EXEC);
            assign w_load_id = r_id;
        end else begin : g_nopipe
            // Add straight from the granted requester and register on accept.
            assign w_op_a    = w_win_a;
            assign w_op_b    = w_win_b;
            assign w_op_cin  = w_win_cin;
            assign w_load    = w_req_hs;
            assign w_load_id = w_grant1;
        end
    endgenerate

    // Full WIDTH+1 bit sum so the carry-out is never lost.
    assign w_res = {1'b0, w_op_a} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, w_op_cin};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode: IDLE -> (EXEC) -> RESP -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_hs) w_state_nxt = (PIPELINE_ENABLE != 0) ? S_EXEC : S_RESP;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant id, priority pointer and the per-port response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio       <= 1'b0;
            r_id         <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_sum   <= '0;
            r_rsp1_sum   <= '0;
            r_rsp0_cout  <= 1'b0;
            r_rsp1_cout  <= 1'b0;
        end else begin
            if (w_req_hs) r_id <= w_grant1;
            if (w_load) begin
                if (w_load_id) begin
                    r_rsp1_valid <= 1'b1;
                    r_rsp1_sum   <= w_res[WIDTH-1:0];
                    r_rsp1_cout  <= w_res[WIDTH];
                end else begin
                    r_rsp0_valid <= 1'b1;
                    r_rsp0_sum   <= w_res[WIDTH-1:0];
                    r_rsp0_cout  <= w_res[WIDTH];
                end
            end
            // Priority only moves once a result has actually been consumed.
            if (w_rsp_hs) begin
                if (r_id) r_rsp1_valid <= 1'b0;
                else      r_rsp0_valid <= 1'b0;
                r_prio <= ~r_id;
            end
        end
    end

    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp0_sum   = r_rsp0_sum;
    assign o_rsp1_sum   = r_rsp1_sum;
    assign o_rsp0_cout  = r_rsp0_cout;
    assign o_rsp1_cout  = r_rsp1_cout;
    assign o_busy       = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_adder_share_arbiter
//  Description : Scoreboard bench for adder_share_arbiter; one instance with
//                a one-cycle datapath and one with the pipelined datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_arbiter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // one-cycle instance
    logic         v0, v1, c0, c1, rdy0, rdy1, rv0, rv1, rr0, rr1, co0, co1, bsy;
    logic [W-1:0] a0, b0, a1, b1, s0, s1;
    // pipelined instance
    logic         pv0, pv1, pc0, pc1, prdy0, prdy1, prv0, prv1, prr0, prr1, pco0, pco1, pbsy;
    logic [W-1:0] pa0, pb0, pa1, pb1, ps0, ps1;

    // expected {cout,sum} for the operation currently offered on each port
    logic [W:0] exp0, exp1, pexp0, pexp1;
    logic [W:0] q0[$], q1[$], pq0[$], pq1[$];

    int errors = 0;
    int checks = 0;

    adder_share_arbiter #(.WIDTH(W), .PIPELINE_ENABLE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .i_req0_valid(v0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_cin(c0), .o_req0_ready(rdy0),
        .i_req1_valid(v1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_cin(c1), .o_req1_ready(rdy1),
        .o_rsp0_valid(rv0), .i_rsp0_ready(rr0), .o_rsp0_sum(s0), .o_rsp0_cout(co0),
        .o_rsp1_valid(rv1), .i_rsp1_ready(rr1), .o_rsp1_sum(s1), .o_rsp1_cout(co1),
        .o_busy(bsy)
    );

    adder_share_arbiter #(.WIDTH(W), .PIPELINE_ENABLE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req0_valid(pv0), .i_req0_a(pa0), .i_req0_b(pb0), .i_req0_cin(pc0), .o_req0_ready(prdy0),
        .i_req1_valid(pv1), .i_req1_a(pa1), .i_req1_b(pb1), .i_req1_cin(pc1), .o_req1_ready(prdy1),
        .o_rsp0_valid(prv0), .i_rsp0_ready(prr0), .o_rsp0_sum(ps0), .o_rsp0_cout(pco0),
        .o_rsp1_valid(prv1), .i_rsp1_ready(prr1), .o_rsp1_sum(ps1), .o_rsp1_cout(pco1),
        .o_busy(pbsy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Scoreboard push: an accepted request enqueues its expected result.
    always @(negedge clk) begin
        if (v0 && rdy0)   q0.push_back(exp0);
        if (v1 && rdy1)   q1.push_back(exp1);
        if (pv0 && prdy0) pq0.push_back(pexp0);
        if (pv1 && prdy1) pq1.push_back(pexp1);
    end

    // Monitor: every response handshake pops and compares.
    always @(negedge clk) begin
        if (!rst) begin
            if (rv0 && rv1)   fail("rsp_both_valid");
            if (prv0 && prv1) fail("prsp_both_valid");
            if (rv0 && rr0) begin
                if (q0.size() == 0) fail("rsp0_unexpected");
                else chk("rsp0_result", 32'({co0, s0}), 32'(q0.pop_front()));
            end
            if (rv1 && rr1) begin
                if (q1.size() == 0) fail("rsp1_unexpected");
                else chk("rsp1_result", 32'({co1, s1}), 32'(q1.pop_front()));
            end
            if (prv0 && prr0) begin
                if (pq0.size() == 0) fail("prsp0_unexpected");
                else chk("prsp0_result", 32'({pco0, ps0}), 32'(pq0.pop_front()));
            end
            if (prv1 && prr1) begin
                if (pq1.size() == 0) fail("prsp1_unexpected");
                else chk("prsp1_result", 32'({pco1, ps1}), 32'(pq1.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int grants[$];
        int exp_order[4];
        int n, last, done;
        bit pend0, pend1, acc0, acc1;

        exp_order = '{0, 1, 0, 1};
        // reset with both requesters valid
        v0 = 1; a0 = 4'h3; b0 = 4'h3; c0 = 1; exp0 = '0;
        v1 = 1; a1 = 4'h5; b1 = 4'h5; c1 = 1; exp1 = '0;
        rr0 = 0; rr1 = 0;
        pv0 = 1; pa0 = 4'h1; pb0 = 4'h1; pc0 = 0; pexp0 = '0;
        pv1 = 1; pa1 = 4'h2; pb1 = 4'h2; pc1 = 0; pexp1 = '0;
        prr0 = 0; prr1 = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req0_ready", 32'(rdy0), 0);
            chk("rst_req1_ready", 32'(rdy1), 0);
            chk("rst_rsp_valids", 32'({rv1, rv0, prv1, prv0}), 0);
            chk("rst_sums", 32'({s1, s0}), 0);
            chk("rst_couts", 32'({co1, co0}), 0);
            chk("rst_busy", 32'({bsy, pbsy}), 0);
            chk("rst_preq_ready", 32'({prdy1, prdy0}), 0);
        end
        @(posedge clk); #1;
        rst = 0; v0 = 0; v1 = 0; pv0 = 0; pv1 = 0;

        // contention: grants alternate starting with requester 0
        @(posedge clk); #1;
        a0 = 4'h1; b0 = 4'h1; c0 = 0; exp0 = 5'h02;
        a1 = 4'hF; b1 = 4'h0; c1 = 1; exp1 = 5'h10;
        v0 = 1; v1 = 1; rr0 = 1; rr1 = 1;
        n = 0; last = 0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            @(negedge clk);
            if (rdy0 || rdy1) begin
                grants.push_back(rdy1 ? 1 : 0);
                if (n > 0) chk("accept_spacing", 32'(cyc - last), 2);
                last = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
        chk("contention_accepts", 32'(n), 4);
        for (int i = 0; i < grants.size() && i < 4; i++)
            chk("grant_order", 32'(grants[i]), 32'(exp_order[i]));
        repeat (3) @(negedge clk);

        // single op on requester 0
        @(posedge clk); #1;
        a0 = 4'h9; b0 = 4'h8; c0 = 1; exp0 = 5'h12; v0 = 1;
        @(negedge clk);
        chk("single_req0_ready", 32'(rdy0), 1);
        chk("single_req1_ready", 32'(rdy1), 0);
        @(posedge clk); #1;
        v0 = 0;
        @(negedge clk);
        chk("single_rsp0_valid", 32'(rv0), 1);
        chk("single_rsp1_valid", 32'(rv1), 0);
        chk("single_busy", 32'(bsy), 1);
        @(negedge clk);
        chk("single_idle_after", 32'(bsy), 0);

        // backpressure on requester 1 while requester 0 waits
        @(posedge clk); #1;
        a1 = 4'h7; b1 = 4'h7; c1 = 0; exp1 = 5'h0E; v1 = 1; rr1 = 0;
        @(negedge clk);
        chk("bp_req1_ready", 32'(rdy1), 1);
        @(posedge clk); #1;
        v1 = 0;
        a0 = 4'h3; b0 = 4'h4; c0 = 0; exp0 = 5'h07; v0 = 1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp1_valid", 32'(rv1), 1);
            chk("bp_rsp1_data", 32'({co1, s1}), 32'h0E);
            chk("bp_req_ready", 32'({rdy1, rdy0}), 0);
        end
        @(posedge clk); #1;
        rr1 = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_after", 32'(bsy), 0);
        chk("bp_req0_granted", 32'(rdy0), 1);
        @(posedge clk); #1;
        v0 = 0;
        repeat (3) @(negedge clk);

        // reset during RESP: pointer currently favours requester 1
        @(posedge clk); #1;
        a1 = 4'h1; b1 = 4'h2; c1 = 0; exp1 = 5'h03; v1 = 1; rr1 = 0;
        @(negedge clk);
        chk("midrst_req1_ready", 32'(rdy1), 1);
        @(posedge clk); #1;
        v1 = 0;
        @(negedge clk);
        chk("midrst_in_resp", 32'(rv1), 1);
        @(posedge clk); #1;
        rst = 1; q1.delete();
        @(posedge clk); #1;
        rst = 0; rr1 = 1;
        a0 = 4'h2; b0 = 4'h2; c0 = 0; exp0 = 5'h04; v0 = 1;
        a1 = 4'h5; b1 = 4'h5; c1 = 1; exp1 = 5'h0B; v1 = 1;
        @(negedge clk);
        chk("midrst_no_rsp", 32'({rv1, rv0}), 0);
        chk("midrst_busy", 32'(bsy), 0);
        chk("midrst_prio_req0", 32'({rdy1, rdy0}), 32'b01);
        @(posedge clk); #1;
        v0 = 0;
        n = 0;
        for (int cyc = 0; cyc < 10 && n == 0; cyc++) begin
            @(negedge clk);
            if (rdy1) n = 1;
        end
        chk("midrst_req1_follows", 32'(n), 1);
        @(posedge clk); #1;
        v1 = 0;
        repeat (3) @(negedge clk);

        // pipelined instance: result two cycles after accept
        @(posedge clk); #1;
        pa0 = 4'hA; pb0 = 4'h6; pc0 = 0; pexp0 = 5'h10; pv0 = 1; prr0 = 1; prr1 = 1;
        @(negedge clk);
        chk("pipe_req0_ready", 32'(prdy0), 1);
        @(posedge clk); #1;
        pv0 = 0;
        @(negedge clk);
        chk("pipe_exec_no_valid", 32'(prv0), 0);
        chk("pipe_exec_busy", 32'(pbsy), 1);
        @(negedge clk);
        chk("pipe_rsp0_valid", 32'(prv0), 1);
        chk("pipe_rsp1_valid", 32'(prv1), 0);
        @(negedge clk);
        chk("pipe_idle_after", 32'(pbsy), 0);

        // pipelined instance: reset during EXEC
        @(posedge clk); #1;
        pa0 = 4'h1; pb0 = 4'h1; pc0 = 0; pexp0 = 5'h02; pv0 = 1;
        @(negedge clk);
        chk("pmidrst_req0_ready", 32'(prdy0), 1);
        @(posedge clk); #1;
        pv0 = 0; rst = 1; pq0.delete();
        @(posedge clk); #1;
        rst = 0;
        pa0 = 4'h4; pb0 = 4'h4; pc0 = 1; pexp0 = 5'h09; pv0 = 1;
        pa1 = 4'h8; pb1 = 4'h8; pc1 = 0; pexp1 = 5'h10; pv1 = 1;
        @(negedge clk);
        chk("pmidrst_no_rsp", 32'({prv1, prv0}), 0);
        chk("pmidrst_busy", 32'(pbsy), 0);
        chk("pmidrst_prio_req0", 32'({prdy1, prdy0}), 32'b01);
        @(posedge clk); #1;
        pv0 = 0;
        n = 0;
        for (int cyc = 0; cyc < 10 && n == 0; cyc++) begin
            @(negedge clk);
            if (prdy1) n = 1;
        end
        chk("pmidrst_req1_follows", 32'(n), 1);
        @(posedge clk); #1;
        pv1 = 0;
        repeat (4) @(negedge clk);

        // random traffic on both ports with random response backpressure
        done = 0; pend0 = 0; pend1 = 0; acc0 = 0; acc1 = 0;
        for (int cyc = 0; cyc < 4000 && done < 200; cyc++) begin
            @(posedge clk); #1;
            if (acc0) begin v0 = 0; pend0 = 0; end
            if (acc1) begin v1 = 0; pend1 = 0; end
            if (!pend0 && $urandom_range(0, 1) == 1) begin
                a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom);
                exp0 = model(a0, b0, c0); v0 = 1; pend0 = 1;
            end
            if (!pend1 && $urandom_range(0, 1) == 1) begin
                a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
                exp1 = model(a1, b1, c1); v1 = 1; pend1 = 1;
            end
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc0 = v0 && rdy0;
            acc1 = v1 && rdy1;
            if (acc0) done++;
            if (acc1) done++;
        end
        @(posedge clk); #1;
        v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        repeat (10) @(negedge clk);
        chk("random_ops_done", 32'(done >= 200), 1);
        chk("scoreboard_drained", 32'(q0.size() + q1.size() + pq0.size() + pq1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit adder datapath (sum = a + b + cin with carry-out) between two requesters. Each requester offers operands on a valid/ready handshake and gets its own result port, also with a valid/ready handshake. The block holds exactly one operation in flight. It sits between the client blocks and the arithmetic datapath; the datapath is optionally pipelined by one register stage.

## Interface
- WIDTH, 4, operand and sum width in bits (≥1)
- PIPELINE_ENABLE, 0, 0: one-cycle datapath; 1: extra register stage, adding one cycle of latency

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  requester N offers an operation
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_cin / req1_cin  in  1  carry-in
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid&ready
- rsp0_valid / rsp1_valid  out  1  result for requester N is present
- rsp0_ready / rsp1_ready  in  1  requester N consumes its result
- rsp0_sum / rsp1_sum  out  WIDTH  result sum
- rsp0_cout / rsp1_cout  out  1  result carry-out
- busy  out  1  high whenever state ≠ IDLE

## Operation
- State machine: IDLE, EXEC, RESP.
- IDLE:
  - If no req valid, stay.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester indicated by the priority pointer `prio`.
  - reqN_ready is combinational: (state==IDLE) & ~rst & reqN_valid & (N is the winner). At most one ready is high.
  - On handshake, latch a, b, cin and the granted id. Next state is EXEC if PIPELINE_ENABLE=1, otherwise RESP.
- EXEC (PIPELINE_ENABLE=1 only): operands pass through the stage register. Unconditionally go to RESP next cycle.
- RESP:
  - rspN_valid=1 only for the granted id; the other rsp valid stays 0.
  - sum/cout are held stable until rspN_ready=1.
  - On handshake, clear rspN_valid, set `prio` to the non-served requester, and go to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, computed at WIDTH+1 bits, with no truncation beyond WIDTH+1.
- The non-granted rsp sum/cout outputs retain their last values; they are only meaningful while the matching valid is high.
- Requester rule: once asserted, reqN_valid and its operands stay stable until ready. The block ignores operand changes while not ready.
- `prio` reset value selects requester 0. `prio` updates only on response handshake, not on request handshake.
- A single requester that alone is valid is always granted, regardless of `prio`.

## Timing
- Reset (rst=1 at a clock edge):
  - state=IDLE, prio=0, rsp0_valid=rsp1_valid=0, rsp sums/couts=0, busy=0.
  - req ready forced 0 while rst is high.
- Reset mid-operation: the in-flight operation is discarded with no response. The next cycle after rst deassertion is IDLE.
- Latency with request handshake at edge t:
  - PIPELINE_ENABLE=0: rspN_valid high from cycle t+1.
  - PIPELINE_ENABLE=1: rspN_valid high from cycle t+2.
- Response handshake at edge r: state is IDLE in cycle r+1, and a new req ready may be high in cycle r+1.
- Minimum spacing between accepted requests is 2 cycles (PIPELINE_ENABLE=0) or 3 cycles (PIPELINE_ENABLE=1).
- Backpressure: rspN_valid held indefinitely with stable data while rspN_ready=0. Meanwhile both req ready signals stay 0.
- rspN_ready asserted while rspN_valid=0 has no effect.
- busy = (state≠IDLE), registered-state decode.

## Test plan
- Reset values: hold rst 3 cycles with both reqs valid. Required: req0_ready=req1_ready=0, rsp valids=0, sums=0, couts=0, busy=0.
- Single op, PIPELINE_ENABLE=0, WIDTH=4: req0 a=4'h9, b=4'h8, cin=1, rsp0_ready=1. Required: req0_ready the same cycle; rsp0_valid one cycle later with sum=4'h2, cout=1; rsp1_valid stays 0.
- Contention: both reqs continuously valid (req0 a=1,b=1,cin=0; req1 a=4'hF,b=4'h0,cin=1), rsp readies tied 1. Required:
  - Grants in the order 0,1,0,1.
  - rsp0 sum=2, cout=0; rsp1 sum=0, cout=1.
  - One accept every 2 cycles.
- Backpressure: accept req1 (a=4'h7,b=4'h7,cin=0) with rsp1_ready=0 for 5 cycles. Required:
  - rsp1_valid held with sum=4'hE, cout=0 for all 5 cycles.
  - Req ready stays 0 while req0 is valid.
  - After rsp1_ready rises: IDLE next cycle, then req0 granted.
- PIPELINE_ENABLE=1: req0 a=4'hA, b=4'h6, cin=0. Required: rsp0_valid exactly 2 cycles after the request handshake, with sum=4'h0, cout=1.
- Reset mid-op: assert rst in the EXEC or RESP cycle. Required: no rsp valid after reset, state IDLE, prio back to 0 (req0 wins the next contention).
- Random: 200 random ops on both ports checked against the a+b+cin model, covering all widths of operands.
